pipe_stage_buf: RTL and testbench

// - Generic, parametrised pipeline register that sits between two core stages
//   (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Carries one packed stage payload plus a valid bit.
// - Adds valid/ready back-pressure, flush, and an optional 2-entry skid slot.
// - Replaces the per-stage hand-written bundles; stage payload structs live
//   in pipe_pkg and are passed in flattened.

---
 rtl/pipe_stage_buf_pkg.sv | 94 +++++++++
 rtl/pipe_stage_buf_if.sv | 21 ++
 rtl/pipe_stage_buf.sv | 138 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Stage payload types and pipeline-register constants shared by every stage
// boundary in the core.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
    } decode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [2:0]  funct3;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } exec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wb_val;
        logic        reg_we;
    } mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wb_val;
        logic        reg_we;
    } back_t;

    // addi x0, x0, 0: writes nothing, touches no memory.
    localparam decode_t NOP_DECODE = '{
        pc:      32'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        rd:      5'd0,
        imm:     32'd0,
        rs1_val: 32'd0,
        rs2_val: 32'd0,
        alu_op:  ALU_ADD,
        funct3:  3'd0,
        reg_we:  1'b0,
        mem_re:  1'b0,
        mem_we:  1'b0,
        branch:  1'b0,
        jump:    1'b0
    };

    function automatic logic [1:0] occ_count(input occ_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            EMPTY:   n = 2'd0;
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/payload bundle between two pipeline stages; the producer uses
// the master modport, the consumer the slave modport.
interface pipe_stage_buf_if #(
    parameter int WIDTH = 160
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline register with valid/ready back-pressure, flush and an optional
// skid entry that breaks the combinational ready path.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int               WIDTH    = 160,
    parameter int               SKID     = 1,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_stage_buf_if.slave     up,
    pipe_stage_buf_if.master    dn,
    output logic [1:0]          occupancy
);

    if (SKID == 0) begin : g_single
        logic             main_valid_q;
        logic             main_valid_d;
        logic [WIDTH-1:0] main_data_q;
        logic [WIDTH-1:0] main_data_d;
        logic             in_ready;
        logic             accept;
        logic             consume;

        assign in_ready = !main_valid_q || dn.ready;
        assign accept   = up.valid && in_ready;
        assign consume  = main_valid_q && dn.ready;

        // An accept on a consume cycle overwrites the departing payload.
        always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            if (flush) begin
                main_valid_d = 1'b0;
                main_data_d  = RST_DATA;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = up.data;
            end else if (consume) begin
                main_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                main_valid_q <= 1'b0;
                main_data_q  <= RST_DATA;
            end else begin
                main_valid_q <= main_valid_d;
                main_data_q  <= main_data_d;
            end
        end

        assign up.ready  = in_ready;
        assign dn.valid  = main_valid_q;
        assign dn.data   = main_data_q;
        assign occupancy = {1'b0, main_valid_q};

    end else begin : g_skid
        occ_e             state_q;
        occ_e             state_d;
        logic [WIDTH-1:0] main_data_q;
        logic [WIDTH-1:0] main_data_d;
        logic [WIDTH-1:0] skid_data_q;
        logic [WIDTH-1:0] skid_data_d;
        logic             in_ready_q;
        logic             in_ready_d;
        logic             out_valid;
        logic [1:0]       occ;
        logic             accept;
        logic             consume;

        assign accept  = up.valid && in_ready_q;
        assign consume = out_valid && dn.ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= EMPTY;
                in_ready_q  <= 1'b1;
                main_data_q <= RST_DATA;
                skid_data_q <= RST_DATA;
            end else begin
                state_q     <= state_d;
                in_ready_q  <= in_ready_d;
                main_data_q <= main_data_d;
                skid_data_q <= skid_data_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !consume)      state_d = TWO;
                    else if (!accept && consume) state_d = EMPTY;
                end
                TWO:     if (consume) state_d = ONE;
                default: state_d = EMPTY;
            endcase
            if (flush) state_d = EMPTY;
            // Registered ready looks at where the FSM is going, not where it is.
            in_ready_d = (state_d != TWO);
        end

        always_comb begin
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
            if (flush) begin
                main_data_d = RST_DATA;
                skid_data_d = RST_DATA;
            end else begin
                case (state_q)
                    EMPTY: if (accept) main_data_d = up.data;
                    ONE: begin
                        if (accept && consume)  main_data_d = up.data;
                        else if (accept)        skid_data_d = up.data;
                    end
                    TWO:     if (consume) main_data_d = skid_data_q;
                    default: ;
                endcase
            end
        end

        always_comb begin
            out_valid = (state_q != EMPTY);
            occ       = occ_count(state_q);
        end

        assign up.ready  = in_ready_q;
        assign dn.valid  = out_valid;
        assign dn.data   = main_data_q;
        assign occupancy = occ;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives both SKID variants with one stimulus stream and checks them against
// a capacity-limited FIFO model, plus literal checks of the directed cases.
module tb_pipe_stage_buf;

    localparam int          W   = 16;
    localparam logic [W-1:0] RD0 = 16'hBEEF;
    localparam logic [W-1:0] RD1 = 16'hDEAD;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic [1:0]   occ0;
    logic [1:0]   occ1;
    logic         chk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.WIDTH(W)) up0 ();
    pipe_stage_buf_if #(.WIDTH(W)) dn0 ();
    pipe_stage_buf_if #(.WIDTH(W)) up1 ();
    pipe_stage_buf_if #(.WIDTH(W)) dn1 ();

    assign up0.valid = in_valid;
    assign up0.data  = in_data;
    assign dn0.ready = out_ready;
    assign up1.valid = in_valid;
    assign up1.data  = in_data;
    assign dn1.ready = out_ready;

    pipe_stage_buf #(.WIDTH(W), .SKID(0), .RST_DATA(RD0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .up(up0), .dn(dn0), .occupancy(occ0)
    );
    pipe_stage_buf #(.WIDTH(W), .SKID(1), .RST_DATA(RD1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .up(up1), .dn(dn1), .occupancy(occ1)
    );

    logic         act_valid [2];
    logic         act_ready [2];
    logic [W-1:0] act_data  [2];
    logic [1:0]   act_occ   [2];
    assign act_valid[0] = dn0.valid;
    assign act_valid[1] = dn1.valid;
    assign act_ready[0] = up0.ready;
    assign act_ready[1] = up1.ready;
    assign act_data[0]  = dn0.data;
    assign act_data[1]  = dn1.data;
    assign act_occ[0]   = occ0;
    assign act_occ[1]   = occ1;

    // Model: each DUT is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
    int           m_size [2] = '{0, 0};
    logic [W-1:0] m_ent  [2][2];
    bit           m_clr  [2] = '{1'b1, 1'b1};
    logic [W-1:0] m_rst  [2] = '{RD0, RD1};

    function automatic bit exp_ready(input int k);
        if (k == 0) return (m_size[0] == 0) || out_ready;
        return m_size[1] < 2;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit acc;
            bit con;
            acc = in_valid && exp_ready(k);
            con = (m_size[k] > 0) && out_ready;
            if (rst || flush) begin
                m_size[k] = 0;
                m_clr[k]  = 1'b1;
            end else begin
                if (con) begin
                    m_ent[k][0] = m_ent[k][1];
                    m_size[k]   = m_size[k] - 1;
                end
                if (acc) begin
                    m_ent[k][m_size[k]] = in_data;
                    m_size[k]           = m_size[k] + 1;
                    m_clr[k]            = 1'b0;
                end
            end
        end
    end

    bit           stall_prev [2] = '{1'b0, 1'b0};
    logic [W-1:0] last_data  [2];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("out_valid", k, 32'(act_valid[k]), 32'(m_size[k] > 0));
                chk("occupancy", k, 32'(act_occ[k]), 32'(m_size[k]));
                chk("in_ready", k, 32'(act_ready[k]), 32'(exp_ready(k)));
                if (m_size[k] > 0)
                    chk("out_data", k, 32'(act_data[k]), 32'(m_ent[k][0]));
                else if (m_clr[k])
                    chk("rst_data", k, 32'(act_data[k]), 32'(m_rst[k]));
                if (stall_prev[k])
                    chk("stall_stable", k, 32'(act_data[k]), 32'(last_data[k]));
                stall_prev[k] = act_valid[k] && !out_ready && !flush && !rst;
                last_data[k]  = act_data[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string what);
        $display("%-14s v1=%0b d1=%h occ1=%0d r1=%0b | v0=%0b d0=%h occ0=%0d",
                 what, act_valid[1], act_data[1], act_occ[1], act_ready[1],
                 act_valid[0], act_data[0], act_occ[0]);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        show("reset");
        chk("lit_rst_valid", 1, 32'(act_valid[1]), 32'd0);
        chk("lit_rst_occ",   1, 32'(act_occ[1]),   32'd0);
        chk("lit_rst_data",  1, 32'(act_data[1]),  32'hDEAD);
        chk("lit_rst_ready", 1, 32'(act_ready[1]), 32'd1);
        chk("lit_rst_data",  0, 32'(act_data[0]),  32'hBEEF);

        // Streaming at full throughput through the skid variant.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = W'(i);
            step();
            show("stream");
            chk("lit_stream_data", 1, 32'(act_data[1]), 32'(i));
            chk("lit_stream_occ",  1, 32'(act_occ[1]),  32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("lit_stream_end", 1, 32'(act_valid[1]), 32'd0);

        // Fill main and skid while stalled, then drain in order.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
        step(); show("push A");
        in_data = 16'h000B;
        step(); show("push B");
        chk("lit_skid_occ",   1, 32'(act_occ[1]),   32'd2);
        chk("lit_skid_ready", 1, 32'(act_ready[1]), 32'd0);
        chk("lit_skid_data",  1, 32'(act_data[1]),  32'h000A);
        in_valid = 1'b0; out_ready = 1'b1;
        step(); show("drain");
        chk("lit_drain_b", 1, 32'(act_data[1]), 32'h000B);
        step(); show("drain");
        chk("lit_drain_empty", 1, 32'(act_valid[1]), 32'd0);

        // Replace-in-place on the single-register variant.
        in_valid = 1'b1; in_data = 16'h0005;
        step(); show("push 5");
        chk("lit_single_5", 0, 32'(act_data[0]), 32'h0005);
        in_data = 16'h0006;
        step(); show("push 6");
        chk("lit_single_6",   0, 32'(act_data[0]), 32'h0006);
        chk("lit_single_occ", 0, 32'(act_occ[0]),  32'd1);
        in_valid = 1'b0;
        step();

        // Flush while full, with an input offered in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
        step();
        in_data = 16'h000B;
        step();
        chk("lit_pre_flush_occ", 1, 32'(act_occ[1]), 32'd2);
        flush = 1'b1; in_data = 16'h000C;
        step(); show("flush");
        chk("lit_flush_occ",   1, 32'(act_occ[1]),   32'd0);
        chk("lit_flush_valid", 1, 32'(act_valid[1]), 32'd0);
        chk("lit_flush_ready", 1, 32'(act_ready[1]), 32'd1);
        chk("lit_flush_data",  1, 32'(act_data[1]),  32'hDEAD);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("lit_post_flush", 1, 32'(act_valid[1]), 32'd0);

        // Flush coinciding with an accept into an empty buffer drops it.
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h0077;
        step(); show("flush+accept");
        chk("lit_flush_drop", 1, 32'(act_occ[1]), 32'd0);
        chk("lit_flush_drop", 0, 32'(act_occ[0]), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();

        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 2);
            rst       = ($urandom_range(0, 999) < 2);
            in_data   = W'($urandom);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
